// File: rtl/vga_image_scanner.sv
// VGA raster scanner: centred 256x256 ROM window, 3-bit to 8-bit grey expansion,
// frame-synchronous image selection. Define WIN_BORDER_EN to draw a white ring around the window.
module vga_image_scanner #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int WIN_X0   = 192,
  parameter int WIN_Y0   = 112
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pix_en,
  input  logic       sel_next,
  output logic [1:0] mem_sel,
  output logic [7:0] xoff,
  output logic [7:0] yoff,
  input  logic [2:0] pixel,
  output logic       hsync,
  output logic       vsync,
  output logic       blank_n,
  output logic [7:0] red,
  output logic [7:0] green,
  output logic [7:0] blue,
  output logic       frame_start
);

  localparam logic [9:0] H_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEGIN = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEGIN = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] X0       = 10'(WIN_X0);
  localparam logic [9:0] Y0       = 10'(WIN_Y0);
  localparam logic [9:0] WIN_SIZE = 10'd256;

  typedef enum logic [1:0] {
    SEL_OLD = 2'd0,
    SEL_NEW = 2'd1,
    SEL_BG  = 2'd2
  } sel_e;

  function automatic sel_e sel_succ(input sel_e s);
    case (s)
      SEL_OLD: return SEL_NEW;
      SEL_NEW: return SEL_BG;
      default: return SEL_OLD;
    endcase
  endfunction

  logic [9:0] h_cnt_q, h_cnt_d;
  logic [9:0] v_cnt_q, v_cnt_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       blank_n_q, blank_n_d;
  logic [7:0] rgb_q, rgb_d;
  logic       frame_start_q, frame_start_d;
  sel_e       sel_q, sel_d;
  logic       pending_q, pending_d;
  logic [2:0] sync_q, sync_d;

  logic [9:0] h_rel, v_rel;
  logic       in_win, visible, border;
  logic       h_wrap, frame_wrap, sel_rise;

  // Unsigned wrap-around makes a single compare cover both sides of the window.
  assign h_rel      = h_cnt_q - X0;
  assign v_rel      = v_cnt_q - Y0;
  assign in_win     = (h_rel < WIN_SIZE) && (v_rel < WIN_SIZE);
  assign visible    = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
  assign h_wrap     = (h_cnt_q == H_LAST);
  assign frame_wrap = h_wrap && (v_cnt_q == V_LAST);
  assign sel_rise   = sync_q[1] & ~sync_q[2];

  assign xoff = in_win ? v_rel[7:0] : 8'h00;
  assign yoff = in_win ? h_rel[7:0] : 8'h00;

`ifdef WIN_BORDER_EN
  logic [9:0] h_ring, v_ring;
  // Ring coordinates: 0 and 257 are the columns/lines just outside the window.
  assign h_ring = h_cnt_q - (X0 - 10'd1);
  assign v_ring = v_cnt_q - (Y0 - 10'd1);
  assign border = ((h_ring == 10'd0 || h_ring == 10'd257) && (v_ring < 10'd258)) ||
                  ((v_ring == 10'd0 || v_ring == 10'd257) && (h_ring < 10'd258));
`else
  assign border = 1'b0;
`endif

  always_comb begin
    // NOTE: every _d gets a hold default first, so no path through this block can infer a latch.
    h_cnt_d       = h_cnt_q;
    v_cnt_d       = v_cnt_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    blank_n_d     = blank_n_q;
    rgb_d         = rgb_q;
    frame_start_d = 1'b0;
    sel_d         = sel_q;
    sync_d        = {sync_q[1:0], sel_next};
    pending_d     = pending_q | sel_rise;

    if (pix_en) begin
      h_cnt_d = h_wrap ? 10'd0 : h_cnt_q + 10'd1;
      if (h_wrap) v_cnt_d = (v_cnt_q == V_LAST) ? 10'd0 : v_cnt_q + 10'd1;

      blank_n_d = visible;
      hsync_d   = !((h_cnt_q >= HS_BEGIN) && (h_cnt_q < HS_END));
      vsync_d   = !((v_cnt_q >= VS_BEGIN) && (v_cnt_q < VS_END));
      if (in_win)
        rgb_d = {pixel, pixel, pixel[2:1]};
      else if (border && visible)
        rgb_d = 8'hFF;
      else
        rgb_d = 8'h00;

      frame_start_d = frame_wrap;
      // An edge landing on the wrap itself stays pending for the next frame.
      if (frame_wrap) begin
        pending_d = sel_rise;
        if (pending_q) sel_d = sel_succ(sel_q);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample the same pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      blank_n_q     <= 1'b0;
      rgb_q         <= '0;
      frame_start_q <= 1'b0;
      sel_q         <= SEL_BG;
      pending_q     <= 1'b0;
      sync_q        <= '0;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      blank_n_q     <= blank_n_d;
      rgb_q         <= rgb_d;
      frame_start_q <= frame_start_d;
      sel_q         <= sel_d;
      pending_q     <= pending_d;
      sync_q        <= sync_d;
    end
  end

  assign mem_sel     = sel_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign blank_n     = blank_n_q;
  assign red         = rgb_q;
  assign green       = rgb_q;
  assign blue        = rgb_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_image_scanner.sv
// Bench for vga_image_scanner: randomized pix_en and button presses against a position-based model.
// Vertical timing is shortened so several frames fit in a short run; horizontal timing is the VGA default.
module tb_vga_image_scanner;

  localparam int H_TOT  = 800;
  localparam int V_ACT  = 8;
  localparam int V_FP   = 2;
  localparam int V_SYN  = 2;
  localparam int V_BPR  = 2;
  localparam int V_TOT  = V_ACT + V_FP + V_SYN + V_BPR;
  localparam int WX0    = 192;
  localparam int WY0    = 3;
  localparam int FRAME  = H_TOT * V_TOT;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pix_en = 1'b0;
  logic       sel_next = 1'b0;
  logic [2:0] pixel;
  logic [1:0] mem_sel;
  logic [7:0] xoff, yoff, red, green, blue;
  logic       hsync, vsync, blank_n, frame_start;

  int tests = 0;
  int fails = 0;
  int t = 0;
  int exp_sel = 2;
  bit exp_pend = 1'b0;
  bit rand_mode = 1'b1;
  int first_hs = -1;
  int vs_low = 0;
  int first_fs = -1;

  vga_image_scanner #(
    .H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
    .V_ACTIVE(V_ACT), .V_FP(V_FP), .V_SYNC(V_SYN), .V_BP(V_BPR),
    .WIN_X0(WX0), .WIN_Y0(WY0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .sel_next(sel_next),
    .mem_sel(mem_sel), .xoff(xoff), .yoff(yoff), .pixel(pixel),
    .hsync(hsync), .vsync(vsync), .blank_n(blank_n),
    .red(red), .green(green), .blue(blue), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  // ROM stub: combinational in address and selected image.
  assign pixel = xoff[2:0] ^ yoff[2:0] ^ {1'b0, mem_sel};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h (step %0d)", tag, obs, exp, t);
    end
  endtask

  function automatic bit in_win(input int h, input int v);
    return h >= WX0 && h < WX0 + 256 && v >= WY0 && v < WY0 + 256;
  endfunction

  function automatic int grey(input int p);
    return ((p << 5) | (p << 2) | (p >> 1)) & 255;
  endfunction

  function automatic int exp_rgb(input int p, input int s);
    int h = p % H_TOT;
    int v = p / H_TOT;
    if (in_win(h, v)) return grey(((v - WY0) ^ (h - WX0) ^ s) & 7);
`ifdef WIN_BORDER_EN
    if (h < 640 && v < V_ACT &&
        (((h == WX0 - 1 || h == WX0 + 256) && v >= WY0 - 1 && v <= WY0 + 256) ||
         ((v == WY0 - 1 || v == WY0 + 256) && h >= WX0 - 1 && h <= WX0 + 256)))
      return 255;
`endif
    return 0;
  endfunction

  function automatic bit rnd_en();
    return rand_mode ? ($urandom_range(0, 7) != 0) : 1'b1;
  endfunction

  task automatic step(input bit en);
    int p, h, v, rgb;
    pix_en = en;
    @(posedge clk);
    #1;
    if (!en) begin
      check("frame_start_idle", frame_start, 0);
      check("mem_sel_idle", mem_sel, exp_sel);
      return;
    end
    t++;
    p = (t - 1) % FRAME;
    h = p % H_TOT;
    v = p / H_TOT;
    rgb = exp_rgb(p, exp_sel);
    check("blank_n", blank_n, (h < 640 && v < V_ACT));
    check("hsync", hsync, !(h >= 656 && h < 752));
    check("vsync", vsync, !(v >= V_ACT + V_FP && v < V_ACT + V_FP + V_SYN));
    check("red", red, rgb);
    check("green", green, rgb);
    check("blue", blue, rgb);
    if (t % FRAME == 0 && exp_pend) begin
      exp_sel = (exp_sel + 1) % 3;
      exp_pend = 1'b0;
    end
    check("frame_start", frame_start, (t % FRAME == 0));
    check("mem_sel", mem_sel, exp_sel);
    p = t % FRAME;
    h = p % H_TOT;
    v = p / H_TOT;
    check("xoff", xoff, in_win(h, v) ? v - WY0 : 0);
    check("yoff", yoff, in_win(h, v) ? h - WX0 : 0);
    if (first_hs < 0 && hsync === 1'b0) first_hs = t;
    if (t <= FRAME && vsync === 1'b0) vs_low++;
    if (first_fs < 0 && frame_start === 1'b1) first_fs = t;
  endtask

  task automatic run_to(input int target);
    int guard = 0;
    while (t < target) begin
      step(rnd_en());
      guard++;
      if (guard > 4 * FRAME) begin
        check("run_to_timeout", t, target);
        break;
      end
    end
  endtask

  // The synchroniser plus edge detector registers the press on the third clk edge.
  task automatic press();
    sel_next = 1'b1;
    for (int i = 0; i < 3; i++) step(rnd_en());
    exp_pend = 1'b1;
    for (int i = 0; i < 2; i++) step(rnd_en());
    sel_next = 1'b0;
    for (int i = 0; i < 4; i++) step(rnd_en());
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_hsync"}, hsync, 1);
    check({tag, "_vsync"}, vsync, 1);
    check({tag, "_blank_n"}, blank_n, 0);
    check({tag, "_red"}, red, 0);
    check({tag, "_green"}, green, 0);
    check({tag, "_blue"}, blue, 0);
    check({tag, "_frame_start"}, frame_start, 0);
    check({tag, "_mem_sel"}, mem_sel, 2);
    check({tag, "_xoff"}, xoff, 0);
    check({tag, "_yoff"}, yoff, 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Frame 1: one mid-frame press, applied only at the wrap.
    run_to(int'($urandom_range(1000, FRAME - 2000)));
    press();
    check("sel_held_mid_frame", mem_sel, 2);
    run_to(FRAME + 50);
    check("first_hsync_low_step", first_hs, 657);
    check("vsync_low_steps", vs_low, 1600);
    check("sel_after_frame1", mem_sel, 0);

    // Frame 2: three presses collapse to one advance.
    run_to(FRAME + int'($urandom_range(500, 2000)));
    press();
    run_to(t + int'($urandom_range(50, 500)));
    press();
    run_to(t + int'($urandom_range(50, 500)));
    press();
    run_to(2 * FRAME + 6 * H_TOT + 300);
    check("sel_before_reset", mem_sel, 1);

    // Asynchronous reset mid-frame, checked before any clk edge.
    rst_n = 1'b0;
    #2;
    check_reset_outputs("async_reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    t = 0;
    exp_sel = 2;
    exp_pend = 1'b0;
    first_fs = -1;

    // Press detected exactly on the wrap edge is carried into the next frame.
    rand_mode = 1'b0;
    run_to(FRAME - 3);
    press();
    check("fs_steps_after_reset", first_fs, FRAME);
    check("sel_wrap_edge_retained", mem_sel, 2);
    run_to(2 * FRAME + 5);
    check("sel_after_retained_edge", mem_sel, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vga_image_scanner.md
Name: vga_image_scanner

Overview:
- Downstream consumer of the image ROM stage. Generates 640x480@60 VGA timing from a pixel-clock enable and drives the ROM row/column address (xoff/yoff) for a 256x256 window centred on screen.
- Registers the returned 3-bit pixel and expands it to 8-bit grey on R/G/B.
- Owns the memorySelect state machine, which cycles OLD -> NEW -> BACKGROUND on a button press. Image changes are applied only at frame boundaries.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync width
- V_BP, 33, vertical back porch
- WIN_X0, 192, first screen column of the image window
- WIN_Y0, 112, first screen line of the image window

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- pix_en  in  1  pixel-clock enable (one clk pulse per pixel; may be tied high)
- sel_next  in  1  raw button level (asynchronous); a rising edge requests the next image
- mem_sel  out  2  memorySelect to ROM: 0=OLD, 1=NEW, 2=BACKGROUND
- xoff  out  8  ROM row index (screen line minus WIN_Y0)
- yoff  out  8  ROM column index (screen column minus WIN_X0)
- pixel  in  3  ROM data, combinational from xoff/yoff/mem_sel
- hsync  out  1  horizontal sync, active low
- vsync  out  1  vertical sync, active low
- blank_n  out  1  high in the visible area
- red, green, blue  out  8 each  grey video
- frame_start  out  1  one-clk pulse at the first pixel of each frame

Behaviour:
- Reset (async, rst_n=0): h_cnt=0, v_cnt=0, hsync=1, vsync=1, blank_n=0, RGB=0, frame_start=0, mem_sel=2, pending=0, synchroniser flops=0.
- Counters advance only on clk edges with pix_en=1. Nothing else changes state on clk edges with pix_en=0, except the sel_next synchroniser.
- h_cnt runs 0..799 and wraps to 0. v_cnt increments when h_cnt wraps, runs 0..524 and wraps to 0.
- Window: in_win = (h_cnt - WIN_X0) < 256 and (v_cnt - WIN_Y0) < 256, evaluated as unsigned compares.
- xoff = v_cnt - WIN_Y0 and yoff = h_cnt - WIN_X0, each taking the low 8 bits. Both are driven combinationally from the counters.
- Outside the window, xoff=0 and yoff=0 (keeps ROM input quiet).
- Output stage: registered, updated on pix_en, one pixel of latency. Outputs at step n reflect the counters and pixel at step n-1.
  - blank_n = (h<H_ACTIVE and v<V_ACTIVE).
  - hsync = 0 for h in [656,751].
  - vsync = 0 for v in [490,491].
  - RGB = grey(pixel) when in_win, else 0.
- Grey expansion: g = {p[2:0], p[2:0], p[2:1]}. Examples: 3'b111 -> 8'hFF, 3'b100 -> 8'h92, 3'b000 -> 8'h00.
- frame_start pulses for one clk on the pix_en edge where the counters wrap from (799,524) to (0,0).
- Selection FSM: states SEL_OLD(0), SEL_NEW(1), SEL_BG(2). Transitions OLD->NEW->BG->OLD.
  - sel_next passes through a 2-flop synchroniser on clk, then a rising-edge detector. Each detected edge sets pending=1.
  - Multiple edges within one frame collapse to a single advance.
  - The state advances, and pending clears, on the same edge that asserts frame_start. mem_sel never changes mid-frame.
  - An edge detected on the frame-wrap edge itself is retained in pending and applied at the next wrap.
- mem_sel is a registered copy of the FSM state.
- Reset mid-frame forces all outputs to their reset values immediately (asynchronous). Scanning restarts at (0,0) with mem_sel=2.

Optional Feature:
- Macro WIN_BORDER_EN.
- Defined: visible pixels where the window test fails but the pixel is within one pixel of the window, i.e. columns WIN_X0-1 and WIN_X0+256, and lines WIN_Y0-1 and WIN_Y0+256, spanning that range, output RGB = 8'hFF.
- Undefined: those pixels output 0. Nothing else differs.

Test Plan:
- Reset release, pix_en=1 -> first hsync low at output step 657 (h=656 plus 1 latency). Line period 800 steps. vsync low for exactly 1600 pix_en steps per 420000-step frame.
- ROM stub returns pixel=yoff[2:0]; screen pixel (h=192, v=112) -> xoff=0, yoff=0 in that step. Next step RGB=8'h00. Pixel (h=199, v=112) -> 3'b111 -> RGB=8'hFF.
- Screen pixel (191,112) and (448,300) -> xoff=yoff=0, RGB=0. blank_n=0 at h=640.
- After reset mem_sel=2. Press sel_next mid-frame -> mem_sel stays 2 until frame_start, then becomes 0. Three presses in one frame -> a single advance, to 0.
- Assert rst_n=0 at h=300, v=200 with mem_sel=1 -> hsync=vsync=1, RGB=0, mem_sel=2 with no clk edge. After release, frame_start occurs 420000 pix_en steps later.
- With WIN_BORDER_EN: pixel (191,200) -> RGB=8'hFF. Without it -> 8'h00.
